static_priority_selector: RTL and testbench
===========================================

Name: static_priority_selector

Overview:
- Combinational, static-priority (lowest index first) multi-way picker for queue entry tables.
- Picks up to EnqWidth free slots for enqueue allocation, from the entry-valid vector.
- Picks up to SelWidth requesting entries for issue/dequeue, from a select-request mask.
- Each pick is a one-hot mask over Depth entries. Sits beside a queue's entry array and drives its allocate and select ports.

Parameters:
Depth  8  number of queue entries (>=1); PtrWidth = $clog2(Depth) available internally
EnqWidth  2  number of free-slot picks per evaluation (>=1)
SelWidth  2  number of select picks per evaluation (>=1)

Ports:
clk  input  1  clock; used only by internal sanity-check logic, no functional state
rst_n  input  1  asynchronous active-low reset; clears internal check state only
entry_vld_i  input  Depth  bit i = 1 means entry i occupied
sel_mask_i  input  Depth  bit i = 1 means entry i requests selection
enq_mask_o  output  [EnqWidth-1:0][Depth-1:0] packed  one-hot free-slot picks
result_mask_o  output  [SelWidth-1:0][Depth-1:0] packed  one-hot select picks

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Both outputs are purely combinational from the inputs: zero-cycle latency, no registers in the data path.
- clk and rst_n never affect outputs. Reset assertion at any time, including mid-operation, leaves outputs as a function of the current inputs only.
- Free-slot pick:
  - Scan entries from index 0 upward over entries with entry_vld_i[i] == 0.
  - enq_mask_o[k] has exactly bit i set, where i is the (k+1)-th such free entry (k = 0..EnqWidth-1).
  - If fewer than k+1 free entries exist, enq_mask_o[k] = 0.
- Select pick:
  - Same rule applied to the set bits of sel_mask_i.
  - result_mask_o[k] = one-hot of the (k+1)-th lowest set bit, else 0.
- sel_mask_i is evaluated as given. It is not masked with entry_vld_i (callers normally supply a subset), and the two pickers are independent.
- Invariants:
  - Each output row is zero or one-hot.
  - Rows within one output are pairwise disjoint.
  - Nonzero rows are contiguous from row 0 with strictly increasing bit positions.
  - The number of nonzero rows is min(popcount, width).
- Boundaries:
  - All entries valid: enq_mask_o all zero.
  - All entries free: enq rows are bits 0..EnqWidth-1.
  - Width > Depth: rows beyond Depth are zero.
- Implementation: cascaded find-first-set with progressive masking of already-picked bits, or prefix-popcount compare. Any equivalent structure is acceptable; no latches.
- Optional internal check (simulation only, synchronous to clk, cleared by rst_n): flag any non-one-hot or overlapping rows.

Test Plan:
- entry_vld_i=8'hFF, sel_mask_i=8'h00 -> enq_mask_o rows 0,1 = 8'h00, 8'h00; result_mask_o rows 0,1 = 8'h00, 8'h00.
- entry_vld_i=8'h00, sel_mask_i=8'hFF -> enq rows 8'h01, 8'h02; result rows 8'h01, 8'h02.
- entry_vld_i=8'b1011_0101, sel_mask_i=8'b1010_0100 -> enq rows 8'h02, 8'h08; result rows 8'h04, 8'h20.
- entry_vld_i=8'h7F, sel_mask_i=8'h40 -> enq rows 8'h80, 8'h00; result rows 8'h40, 8'h00.
- Random: 100000 vectors with entry_vld_i random and sel_mask_i = random & entry_vld_i, compared against a golden lowest-index-first scan model -> exact match on every row, fatal on mismatch.
- Toggle rst_n low then high while holding entry_vld_i=8'b1011_0101 -> outputs stay 8'h02, 8'h08 throughout with no glitch to reset values.

Source files
------------

// File: rtl/static_priority_selector.sv
// static_priority_selector
// Lowest-index-first multi-way picker for a queue entry table.
// enq_mask_o picks up to EnqWidth free slots (entry_vld_i == 0);
// result_mask_o picks up to SelWidth requesting entries (sel_mask_i == 1).
// Both pickers are purely combinational and independent of each other.
// clk/rst_n only drive a simulation-side sanity checker that never
// feeds back into the data path.
module static_priority_selector #(
   parameter int Depth    = 8,
   parameter int EnqWidth = 2,
   parameter int SelWidth = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [Depth-1:0]                   entry_vld_i,
   input  logic [Depth-1:0]                   sel_mask_i,
   output logic [EnqWidth-1:0][Depth-1:0]     enq_mask_o,
   output logic [SelWidth-1:0][Depth-1:0]     result_mask_o
);

   // Constant one at entry-vector width, used for lowest-set-bit isolation.
   localparam logic [Depth-1:0] LsbOne = Depth'(1);

   // ------------------------------------------------------------------
   // Data path
   // ------------------------------------------------------------------

   // Candidates not yet taken by an earlier row of each picker.
   logic [Depth-1:0] free_left;
   logic [Depth-1:0] req_left;

   // Free-slot picker: cascaded find-first-set, clearing each pick before the next row.
   always_comb begin
      free_left = ~entry_vld_i;
      for (int k = 0; k < EnqWidth; k++) begin
         // x & -x isolates the lowest set bit; yields zero once nothing is left.
         enq_mask_o[k] = free_left & (~free_left + LsbOne);
         free_left     = free_left & ~enq_mask_o[k];
      end
   end

   // Select picker: same cascade over the request mask, taken as given.
   always_comb begin
      req_left = sel_mask_i;
      for (int k = 0; k < SelWidth; k++) begin
         result_mask_o[k] = req_left & (~req_left + LsbOne);
         req_left         = req_left & ~result_mask_o[k];
      end
   end

   // ------------------------------------------------------------------
   // Sanity checker (no influence on outputs)
   // ------------------------------------------------------------------

   logic             enq_bad;
   logic             sel_bad;
   logic [Depth-1:0] enq_row;
   logic [Depth-1:0] enq_seen;
   logic [Depth-1:0] enq_prev;
   logic [Depth-1:0] sel_row;
   logic [Depth-1:0] sel_seen;
   logic [Depth-1:0] sel_prev;
   int               enq_avail;
   int               enq_rows;
   int               enq_want;
   int               sel_avail;
   int               sel_rows;
   int               sel_want;

   // Free-slot output invariants: one-hot rows, disjoint, drawn from free
   // entries, contiguous from row 0, strictly increasing, min(free, width) rows.
   always_comb begin
      enq_bad   = 1'b0;
      enq_row   = '0;
      enq_seen  = '0;
      enq_prev  = '0;
      enq_avail = 0;
      enq_rows  = 0;
      enq_want  = 0;
      for (int i = 0; i < Depth; i++) begin
         if (!entry_vld_i[i]) enq_avail++;
      end
      for (int k = 0; k < EnqWidth; k++) begin
         enq_row = enq_mask_o[k];
         if ((enq_row & (enq_row - LsbOne)) != '0) enq_bad = 1'b1;
         if ((enq_row & enq_seen) != '0)           enq_bad = 1'b1;
         if ((enq_row & entry_vld_i) != '0)        enq_bad = 1'b1;
         if (k > 0 && enq_row != '0 && (enq_prev == '0 || enq_row <= enq_prev))
            enq_bad = 1'b1;
         if (enq_row != '0) enq_rows++;
         enq_seen = enq_seen | enq_row;
         enq_prev = enq_row;
      end
      enq_want = (enq_avail < EnqWidth) ? enq_avail : EnqWidth;
      if (enq_rows != enq_want) enq_bad = 1'b1;
   end

   // Select output invariants: same rules against the request mask.
   always_comb begin
      sel_bad   = 1'b0;
      sel_row   = '0;
      sel_seen  = '0;
      sel_prev  = '0;
      sel_avail = 0;
      sel_rows  = 0;
      sel_want  = 0;
      for (int i = 0; i < Depth; i++) begin
         if (sel_mask_i[i]) sel_avail++;
      end
      for (int k = 0; k < SelWidth; k++) begin
         sel_row = result_mask_o[k];
         if ((sel_row & (sel_row - LsbOne)) != '0) sel_bad = 1'b1;
         if ((sel_row & sel_seen) != '0)           sel_bad = 1'b1;
         if ((sel_row & ~sel_mask_i) != '0)        sel_bad = 1'b1;
         if (k > 0 && sel_row != '0 && (sel_prev == '0 || sel_row <= sel_prev))
            sel_bad = 1'b1;
         if (sel_row != '0) sel_rows++;
         sel_seen = sel_seen | sel_row;
         sel_prev = sel_row;
      end
      sel_want = (sel_avail < SelWidth) ? sel_avail : SelWidth;
      if (sel_rows != sel_want) sel_bad = 1'b1;
   end

   logic enq_err_q;
   logic sel_err_q;

   // Sticky violation flags, sampled on clk and cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enq_err_q <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         enq_err_q <= enq_err_q | enq_bad;
         sel_err_q <= sel_err_q | sel_bad;
      end
   end

   a_enq_invariants : assert property (@(posedge clk) disable iff (!rst_n) !enq_err_q);
   a_sel_invariants : assert property (@(posedge clk) disable iff (!rst_n) !sel_err_q);

endmodule

// File: tb/tb_static_priority_selector.sv
// Directed bench for static_priority_selector: hand-computed vectors, an
// exhaustive sweep of entry_vld against a lowest-index scan model, a
// reset-toggle glitch watch, and a narrow instance where widths exceed depth.
module tb_static_priority_selector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]      entry_vld = 8'hFF;
  logic [7:0]      sel_mask = 8'h00;
  logic [1:0][7:0] enq_mask;
  logic [1:0][7:0] result_mask;

  logic [1:0]      s_vld = 2'b11;
  logic [1:0]      s_sel = 2'b00;
  logic [3:0][1:0] s_enq;
  logic [2:0][1:0] s_res;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];
  logic watch = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  static_priority_selector #(.Depth(8), .EnqWidth(2), .SelWidth(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entry_vld_i   (entry_vld),
    .sel_mask_i    (sel_mask),
    .enq_mask_o    (enq_mask),
    .result_mask_o (result_mask)
  );

  static_priority_selector #(.Depth(2), .EnqWidth(4), .SelWidth(3)) dut_small (
    .clk           (clk),
    .rst_n         (rst_n),
    .entry_vld_i   (s_vld),
    .sel_mask_i    (s_sel),
    .enq_mask_o    (s_enq),
    .result_mask_o (s_res)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // golden lowest-index-first scan: returns {row1, row0}
  function automatic logic [15:0] scan(input logic [7:0] m);
    logic [7:0] r0;
    logic [7:0] r1;
    int cnt;
    r0 = '0;
    r1 = '0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        if (cnt == 0) r0[i] = 1'b1;
        else if (cnt == 1) r1[i] = 1'b1;
        cnt++;
      end
    end
    return {r1, r0};
  endfunction

  // driver
  task automatic apply(input logic [7:0] v, input logic [7:0] s);
    @(negedge clk);
    entry_vld = v;
    sel_mask = s;
    #1;
  endtask

  task automatic vector(input string tag, input logic [7:0] v, input logic [7:0] s,
                        input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] r0, input logic [7:0] r1);
    apply(v, s);
    exp_q.push_back({24'h0, e0});
    exp_q.push_back({24'h0, e1});
    exp_q.push_back({24'h0, r0});
    exp_q.push_back({24'h0, r1});
    check({tag, "_enq0"}, {24'h0, enq_mask[0]}, exp_q.pop_front());
    check({tag, "_enq1"}, {24'h0, enq_mask[1]}, exp_q.pop_front());
    check({tag, "_res0"}, {24'h0, result_mask[0]}, exp_q.pop_front());
    check({tag, "_res1"}, {24'h0, result_mask[1]}, exp_q.pop_front());
  endtask

  // outputs must never move while reset toggles under constant inputs
  always @(enq_mask or result_mask) begin
    if (watch) begin
      check("rst_glitch_enq", {16'h0, enq_mask}, 32'h0000_0802);
      check("rst_glitch_res", {16'h0, result_mask}, 32'h0000_2004);
    end
  end

  initial begin
    logic [15:0] ge;
    logic [15:0] gs;
    logic [7:0]  s;

    // outputs are live even while reset is held
    vector("all_valid", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    vector("all_free", 8'h00, 8'hFF, 8'h01, 8'h02, 8'h01, 8'h02);
    vector("mixed", 8'b1011_0101, 8'b1010_0100, 8'h02, 8'h08, 8'h04, 8'h20);
    vector("one_free", 8'h7F, 8'h40, 8'h80, 8'h00, 8'h40, 8'h00);
    vector("top_two", 8'h3F, 8'hC0, 8'h40, 8'h80, 8'h40, 8'h80);
    // request mask is not masked by entry_vld
    vector("sel_unmasked", 8'hF0, 8'h0A, 8'h01, 8'h02, 8'h02, 8'h08);

    // exhaustive entry_vld, request mask a random subset of it
    for (int v = 0; v < 256; v++) begin
      s = v[7:0] & 8'($urandom_range(0, 255));
      apply(v[7:0], s);
      ge = scan(~v[7:0]);
      gs = scan(s);
      check("sweep_enq", {16'h0, enq_mask}, {16'h0, ge});
      check("sweep_res", {16'h0, result_mask}, {16'h0, gs});
    end

    // unconstrained request mask
    for (int n = 0; n < 256; n++) begin
      apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      ge = scan(~entry_vld);
      gs = scan(sel_mask);
      check("rand_enq", {16'h0, enq_mask}, {16'h0, ge});
      check("rand_res", {16'h0, result_mask}, {16'h0, gs});
    end

    // reset toggle under held inputs
    apply(8'b1011_0101, 8'b1010_0100);
    check("rst_pre_enq", {16'h0, enq_mask}, 32'h0000_0802);
    check("rst_pre_res", {16'h0, result_mask}, 32'h0000_2004);
    watch = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_low_enq", {16'h0, enq_mask}, 32'h0000_0802);
    check("rst_low_res", {16'h0, result_mask}, 32'h0000_2004);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_enq", {16'h0, enq_mask}, 32'h0000_0802);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_enq", {16'h0, enq_mask}, 32'h0000_0802);
    @(posedge clk);
    #1;
    check("rst_post_res", {16'h0, result_mask}, 32'h0000_2004);
    watch = 1'b0;

    // widths larger than depth: extra rows stay zero
    @(negedge clk);
    s_vld = 2'b00;
    s_sel = 2'b10;
    #1;
    check("small_enq_free", {24'h0, s_enq}, 32'h0000_0009);
    check("small_res_one", {26'h0, s_res}, 32'h0000_0002);
    @(negedge clk);
    s_vld = 2'b01;
    s_sel = 2'b11;
    #1;
    check("small_enq_one", {24'h0, s_enq}, 32'h0000_0002);
    check("small_res_two", {26'h0, s_res}, 32'h0000_0009);
    @(negedge clk);
    s_vld = 2'b11;
    s_sel = 2'b00;
    #1;
    check("small_enq_none", {24'h0, s_enq}, 32'h0000_0000);
    check("small_res_none", {26'h0, s_res}, 32'h0000_0000);

    // final report
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
